// File: rtl/definitions.sv
// Shared types for the registered sequential ALU and its iterative multiplier.
package definitions;

    // Opcode set of the ALU; values outside this list behave as NOP.
    typedef enum logic [4:0] {
        NOP  = 5'd0,
        ADD  = 5'd1,
        ADDI = 5'd2,
        SUB  = 5'd3,
        SUBI = 5'd4,
        AND  = 5'd5,
        ANDI = 5'd6,
        XOR  = 5'd7,
        RXOR = 5'd8,
        LSL  = 5'd9,
        LSR  = 5'd10,
        MOVA = 5'd11,
        MOVB = 5'd12,
        CEQ  = 5'd13,
        CNE  = 5'd14,
        CLE  = 5'd15,
        CLT  = 5'd16,
        MUL  = 5'd17
    } op_t;

    // Control FSM: idle/accepting, or stepping the multiplier.
    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_t;

    // Flag set registered alongside the result.
    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle,
// W steps per product. The product of the final step is presented
// combinationally together with done_o so the caller can capture it on the
// same edge that retires the last step.
module mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   mcand_i,
    input  logic [W-1:0]   mplier_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] prod_q;
    logic [W-1:0]   mcand_q;
    logic [CW-1:0]  cnt_q;
    logic [W:0]     partial;
    logic [2*W-1:0] step;

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        partial = {1'b0, prod_q[2*W-1:W]};
        if (prod_q[0]) begin
            partial = {1'b0, prod_q[2*W-1:W]} + {1'b0, mcand_q};
        end
        step = {partial, prod_q[W-1:1]};
    end

    // Load operands on start, then step once per cycle until the counter runs out.
    // NOTE: the datapath registers are reset along with the counter so that an
    // aborted multiply leaves no stale partial product behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            prod_q  <= {{W{1'b0}}, mplier_i};
            mcand_q <= mcand_i;
            cnt_q   <= CW'(W);
        end else if (cnt_q != '0) begin
            prod_q  <= step;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    assign done_o    = (cnt_q == CW'(1));
    assign product_o = step;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides, a full flag set held
// with the result, and an iterative W-cycle unsigned multiply. The output
// register is a one-entry buffer that can drain and refill in the same cycle.
module seq_alu
    import definitions::*;
#(
    parameter int W     = 8,
    parameter int IMM_W = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  op_t              OP,
    input  logic [W-1:0]     InputA,
    input  logic [W-1:0]     InputB,
    input  logic [IMM_W-1:0] Imm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [W-1:0]     Out,
    output logic [W-1:0]     OutHi,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    alu_state_t state_q, state_d;

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_q, out_d;
    logic [W-1:0]   out_hi_q, out_hi_d;
    flags_t         flags_q, flags_d;

    logic           accept;
    logic           load_alu;
    logic           load_mul;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    logic [W-1:0]   imm_ext;
    logic [W-1:0]   b_eff;
    logic [W:0]     add_full;
    logic [W:0]     sub_full;
    logic           shift_oob;
    logic [W-1:0]   alu_res;
    logic           alu_carry;
    logic           alu_ovf;

    mul_iter #(.W(W)) u_mul (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .start_i   (mul_start),
        .mcand_i   (InputA),
        .mplier_i  (InputB),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Shared operand preparation: immediate ops replace B with the zero-extended Imm.
    always_comb begin
        imm_ext   = W'(Imm);
        b_eff     = (OP == ADDI || OP == SUBI || OP == ANDI) ? imm_ext : InputB;
        add_full  = {1'b0, InputA} + {1'b0, b_eff};
        sub_full  = {1'b0, InputA} - {1'b0, b_eff};
        shift_oob = (32'(Imm) >= 32'(W));
    end

    // Single-cycle op mux with per-op carry/overflow; NOP and unknown opcodes yield zero.
    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (OP)
            ADD, ADDI: begin
                alu_res   = add_full[W-1:0];
                alu_carry = add_full[W];
                alu_ovf   = (InputA[W-1] == b_eff[W-1]) && (add_full[W-1] != InputA[W-1]);
            end
            SUB, SUBI: begin
                alu_res   = sub_full[W-1:0];
                alu_carry = sub_full[W];
                alu_ovf   = (InputA[W-1] != b_eff[W-1]) && (sub_full[W-1] != InputA[W-1]);
            end
            AND, ANDI: alu_res = InputA & b_eff;
            XOR:       alu_res = InputA ^ InputB;
            RXOR:      alu_res = W'(^InputA);
            LSL:       alu_res = shift_oob ? '0 : (InputA << Imm);
            LSR:       alu_res = shift_oob ? '0 : (InputA >> Imm);
            MOVA:      alu_res = InputA;
            MOVB:      alu_res = InputB;
            CEQ:       alu_res = W'(InputA == InputB);
            CNE:       alu_res = W'(InputA != InputB);
            CLE:       alu_res = W'(InputA <= InputB);
            CLT:       alu_res = W'(InputA < InputB);
            default:   alu_res = '0;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter MUL_BUSY on a MUL accept, leave when the last step retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_start) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and the load strobes for the result register and multiplier.
    always_comb begin
        InReady   = (state_q == IDLE) && (!out_valid_q || OutReady);
        accept    = InValid && InReady;
        mul_start = accept && (OP == MUL);
        load_alu  = accept && (OP != MUL);
        load_mul  = (state_q == MUL_BUSY) && mul_done;
    end

    // Next contents of the result register: new ALU or MUL result, else hold.
    always_comb begin
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
        end
        if (load_alu) begin
            out_d            = alu_res;
            out_hi_d         = '0;
            flags_d.zero     = (alu_res == '0);
            flags_d.carry    = alu_carry;
            flags_d.negative = alu_res[W-1];
            flags_d.overflow = alu_ovf;
            out_valid_d      = 1'b1;
        end else if (load_mul) begin
            out_d            = mul_product[W-1:0];
            out_hi_d         = mul_product[2*W-1:W];
            flags_d.zero     = (mul_product == '0);
            flags_d.carry    = (mul_product[2*W-1:W] != '0);
            flags_d.negative = mul_product[W-1];
            flags_d.overflow = 1'b0;
            out_valid_d      = 1'b1;
        end
    end

    // Result register: value, high half, flags and valid bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_hi_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Out      = out_q;
    assign OutHi    = out_hi_q;
    assign Zero     = flags_q.zero;
    assign Carry    = flags_q.carry;
    assign Negative = flags_q.negative;
    assign Overflow = flags_q.overflow;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the combinational datapath ALU. It has a `W`-bit datapath and a valid/ready handshake on both input and output. Results and a full flag set (Zero, Carry, Negative, Overflow) are held in an output register. It adds an iterative unsigned multiply that produces a 2W-bit product over W cycles. It sits between the register file / immediate decode and the writeback/branch unit of the multi-cycle core.

## Interface
Parameters:
- `W`, 8: datapath width, 4..32.
- `IMM_W`, 5: immediate width, must be ≤ W; zero-extended to W.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  operation request.
- `InReady`  out  1  block accepts request this cycle.
- `OP`  in  5  opcode, type `op_t`.
- `InputA`, `InputB`  in  W  operands.
- `Imm`  in  IMM_W  immediate / shift amount.
- `OutValid`  out  1  result register holds an undelivered result.
- `OutReady`  in  1  consumer takes result.
- `Out`  out  W  result (low half for MUL).
- `OutHi`  out  W  MUL high half; 0 for all other ops.
- `Zero`, `Carry`, `Negative`, `Overflow`  out  1 each  flags registered with `Out`.

## Operation
- Accept = `InValid && InReady`. Operands and OP are sampled on the accepting edge and are don't-care afterwards.
- `InReady = (state==IDLE) && (!OutValid || OutReady)`. This gives a one-entry output buffer with same-cycle drain-and-refill.
- Ops:
  - ADD, ADDI, SUB, SUBI are W-bit modular.
  - AND, ANDI, XOR operate bitwise.
  - RXOR: Out = {0…, ^InputA}.
  - LSL, LSR shift InputA by Imm. A shift amount ≥ W gives 0.
  - MOVA → InputA; MOVB → InputB.
  - CEQ, CNE, CLE, CLT are unsigned compares: Out = {0…, result}.
  - MUL: unsigned {OutHi,Out} = A×B.
  - NOP and undefined OP values → Out=0 and are still accepted and returned.
- Flags:
  - Zero = (Out==0), plus (OutHi==0) for MUL.
  - Negative = Out[W-1].
  - ADD/ADDI: Carry = carry-out; Overflow = signed overflow.
  - SUB/SUBI: Carry = borrow (A < B_eff unsigned); Overflow = signed overflow.
  - MUL: Carry = (OutHi≠0); Overflow = 0.
  - All other ops: Carry = 0, Overflow = 0.
- FSM states:
  - IDLE: on accept of a non-MUL op, load the result register and set OutValid. On accept of MUL, go to MUL_BUSY and load the multiplier, counter = W.
  - MUL_BUSY: one shift-add step per cycle, counter decrements. At counter==1, load `{OutHi,Out}` and flags, set OutValid, return to IDLE. InReady = 0 throughout.
- OutValid clears on `OutValid && OutReady` unless a new accept happens in the same cycle. If it does, the new result replaces the old one and OutValid stays 1.
- Out, OutHi and flags are stable while `OutValid && !OutReady`.

## Timing
- Reset (async assert, sync-to-Clk deassert is the system's job): state=IDLE, OutValid=0, Out=0, OutHi=0, all flags 0, multiplier registers 0. InReady=1 from the first cycle after reset.
- Non-MUL latency: accept on edge N → OutValid=1 after edge N, so the result is visible in cycle N+1.
- MUL latency: accept on edge N → OutValid=1 after edge N+W. InReady is low for cycles N+1..N+W.
- Throughput: 1 op/cycle for non-MUL ops with OutReady held high; 1 MUL per W+1 cycles.
- Reset mid-MUL aborts the operation and produces no result.
- OutReady is ignored when OutValid=0.

## Structure
- Add to package `definitions`:
  - `typedef enum logic [4:0] op_t`: NOP, ADD, ADDI, SUB, SUBI, AND, ANDI, XOR, RXOR, LSL, LSR, MOVA, MOVB, CEQ, CNE, CLE, CLT, MUL.
  - `typedef enum logic alu_state_t {IDLE, MUL_BUSY}`.
- Sub-module `mul_iter` (parameter W): shift-add multiplier with start/done ports, product register and counter. `seq_alu` holds the combinational op mux, flag logic, FSM and output register.

## Test plan
- W=8, ADD A=0xFF B=0x01 → next cycle Out=0x00, Zero=1, Carry=1, Overflow=0, Negative=0.
- SUBI A=0x80 Imm=1 → Out=0x7F, Overflow=1, Carry=0. Then SUB A=0x00 B=0x01 → Out=0xFF, Carry=1, Negative=1.
- MUL A=0xFF B=0xFF → Out=0x01, OutHi=0xFE, Carry=1. OutValid rises exactly 8 cycles after accept; InReady=0 in between.
- Back-to-back: ADD/XOR/LSR(Imm=9 → 0)/RXOR(0x07 → 1) on consecutive cycles with OutReady=1 → four results on four consecutive cycles. Then hold OutReady=0 for 3 cycles → Out stable, InReady=0, no result lost.
- Reset_n low during cycle 4 of a MUL → OutValid=0 and Out=0 immediately. After release, InReady=1 and the next ADD 3+4 returns 7.
- Undefined OP 5'h1F → accepted; Out=0, Zero=1, other flags 0.
